// File: rtl/fb_pkg.sv
// Shared definitions for the ping-pong framebuffer swap controller:
// geometry helpers and the controller state encoding.
package fb_pkg;

  // Controller phases: clear the back bank, let the plotter draw into it,
  // then hold until the scan-out end-of-frame pulse exchanges the banks.
  typedef enum logic [1:0] {
    CLEAR     = 2'd0,
    DRAW      = 2'd1,
    WAIT_SWAP = 2'd2
  } fb_state_e;

  // Number of pixels in one bank.
  function automatic int fb_pixels(input int hor, input int ver);
    return hor * ver;
  endfunction

  // Address width needed to reach every pixel of one bank.
  function automatic int fb_addr_width(input int hor, input int ver);
    return $clog2(hor * ver);
  endfunction

endpackage

// File: rtl/fb_clear_seq.sv
// Clear-address sequencer: walks 0..PIXELS-1 while enabled and flags the
// final address so the controller knows the back bank is fully blank.
module fb_clear_seq
  import fb_pkg::*;
#(
  parameter int PIXELS     = 307200,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXELS - 1);

  assign last = (addr == LAST_ADDR);

  // Address counter: restart on reset or a new clear, step while enabled,
  // and fall back to 0 after the terminal address.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      addr <= '0;
    end else if (en) begin
      addr <= last ? '0 : addr + 1'b1;
    end
  end

endmodule

// File: rtl/fb_swap_ctrl.sv
// Double-buffer controller for the 1-bpp VGA framebuffer. Owns the front
// bank select, clears the back bank after every exchange, then lends the
// back-bank write port to the plotter until it reports a finished frame.
// Banks exchange only on the scan-out end-of-frame pulse, so scan-out
// never sees a partially drawn frame.
//
// Plotter handshake: a pixel write is accepted in any cycle where
// draw_valid and draw_ready are both high (zero-latency pass-through to the
// write port); draw_done is only honoured while draw_ready is high, and a
// pixel presented alongside draw_done is still written.
module fb_swap_ctrl
  import fb_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int FRAME_CNT_WIDTH   = 8,
  localparam int PIXELS     = fb_pixels(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS),
  localparam int ADDR_WIDTH = fb_addr_width(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vga_swap,
  input  logic                       draw_valid,
  input  logic [ADDR_WIDTH-1:0]      draw_addr,
  input  logic                       draw_data,
  output logic                       draw_ready,
  input  logic                       draw_done,
  output logic                       wr_en,
  output logic                       wr_bank,
  output logic [ADDR_WIDTH-1:0]      wr_addr,
  output logic                       wr_data,
  output logic                       front_bank,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

  // One extra bit so PIXELS is representable even when it is a power of two.
  localparam logic [ADDR_WIDTH:0] PIXELS_EXT = (ADDR_WIDTH + 1)'(PIXELS);

  fb_state_e             state;
  fb_state_e             next_state;
  logic [ADDR_WIDTH-1:0] clear_addr;
  logic                  clear_last;
  logic                  swap_now;
  logic                  addr_ok;

  // Exchange happens only when a finished frame is waiting for the pulse.
  assign swap_now = (state == WAIT_SWAP) && vga_swap;
  assign addr_ok  = ({1'b0, draw_addr} < PIXELS_EXT);
  assign wr_bank  = ~front_bank;

  fb_clear_seq #(
    .PIXELS     (PIXELS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clk   (clk),
    .rst   (rst),
    .start (swap_now),
    .en    (state == CLEAR),
    .addr  (clear_addr),
    .last  (clear_last)
  );

  // Write-port mux and next-state decode; reset holds the port idle.
  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    wr_addr    = clear_addr;
    wr_data    = 1'b0;
    draw_ready = 1'b0;
    case (state)
      CLEAR: begin
        wr_en = ~rst;
        if (clear_last) next_state = DRAW;
      end
      DRAW: begin
        draw_ready = ~rst;
        wr_en      = ~rst & draw_valid & addr_ok;
        wr_addr    = draw_addr;
        wr_data    = draw_data;
        if (draw_done) next_state = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (vga_swap) next_state = CLEAR;
      end
      default: next_state = CLEAR;
    endcase
  end

  // State, bank select and completed-swap counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      front_bank  <= 1'b0;
      frame_count <= '0;
    end else begin
      state <= next_state;
      if (swap_now) begin
        front_bank  <= ~front_bank;
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Bench for fb_swap_ctrl at a 4x2 framebuffer (8 pixels, 3-bit address),
// plus a 3x3 instance used for the out-of-range address boundary.
module tb_fb_swap_ctrl;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int NP = H * V;
  localparam int AW = 3;
  localparam int FW = 8;
  localparam int EW = 1 + 1 + AW + 1 + 1 + 1 + FW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          vga_swap = 1'b0;
  logic          draw_valid = 1'b0;
  logic [AW-1:0] draw_addr = '0;
  logic          draw_data = 1'b0;
  logic          draw_done = 1'b0;
  logic          draw_ready, wr_en, wr_bank, wr_data, front_bank;
  logic [AW-1:0] wr_addr;
  logic [FW-1:0] frame_count;

  fb_swap_ctrl #(.HOR_ACTIVE_PIXELS(H), .VER_ACTIVE_PIXELS(V), .FRAME_CNT_WIDTH(FW)) u_dut (
    .clk(clk), .rst(rst), .vga_swap(vga_swap), .draw_valid(draw_valid),
    .draw_addr(draw_addr), .draw_data(draw_data), .draw_ready(draw_ready),
    .draw_done(draw_done), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_data(wr_data), .front_bank(front_bank), .frame_count(frame_count)
  );

  // 3x3 instance: 9 pixels in a 4-bit address, so addresses 9..15 are out of range
  logic [3:0] draw_addr2 = '0;
  logic       draw_ready2, wr_en2, wr_bank2, wr_data2, front_bank2;
  logic [3:0] wr_addr2;
  logic [FW-1:0] frame_count2;

  fb_swap_ctrl #(.HOR_ACTIVE_PIXELS(3), .VER_ACTIVE_PIXELS(3), .FRAME_CNT_WIDTH(FW)) u_dut2 (
    .clk(clk), .rst(rst), .vga_swap(vga_swap), .draw_valid(draw_valid),
    .draw_addr(draw_addr2), .draw_data(draw_data), .draw_ready(draw_ready2),
    .draw_done(draw_done), .wr_en(wr_en2), .wr_bank(wr_bank2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .front_bank(front_bank2), .frame_count(frame_count2)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // scoreboard: one expected output vector per checked cycle
  logic [EW-1:0] exp_q[$];

  // reference model: pixels left to blank, whether the plotter owns the
  // port, the displayed bank and the number of exchanges so far
  int m_clear_left = NP;
  bit m_drawing    = 1'b0;
  bit m_front      = 1'b0;
  int m_frames     = 0;

  bit         chk2 = 1'b0;
  bit         exp2 = 1'b0;
  logic [3:0] a2_force = '0;

  function automatic logic [EW-1:0] pack(input bit en, input bit bank, input logic [AW-1:0] a,
                                         input bit d, input bit rdy, input bit fr, input int fc);
    logic [AW-1:0] am;
    bit dm;
    am = en ? a : '0;
    dm = en ? d : 1'b0;
    return {en, bank, am, dm, rdy, fr, FW'(fc)};
  endfunction

  // driver: apply one cycle of stimulus, predict its outputs, advance the model
  task automatic step(input bit r, input bit sw, input bit v, input int a, input bit d,
                      input bit dn);
    bit e_en, e_rdy, e_d;
    logic [AW-1:0] e_a;
    rst        = r;
    vga_swap   = sw;
    draw_valid = v;
    draw_addr  = AW'(a);
    draw_data  = d;
    draw_done  = dn;
    draw_addr2 = chk2 ? a2_force : {1'b0, AW'(a)};
    e_en = 0; e_rdy = 0; e_d = 0; e_a = '0;
    if (!r) begin
      if (m_clear_left > 0) begin
        e_en = 1; e_a = AW'(NP - m_clear_left);
      end else if (m_drawing) begin
        e_rdy = 1; e_en = v && (a < NP); e_a = AW'(a); e_d = d;
      end
    end
    exp_q.push_back(pack(e_en, ~m_front, e_a, e_d, e_rdy, m_front, m_frames));
    if (chk2) begin
      #2;
      n_assert++;
      if (wr_en2 !== exp2)
        $display("FAIL addr_range a2=%0d wr_en2 got %b want %b", a2_force, wr_en2, exp2);
      if (wr_en2 !== exp2) n_fail++;
      chk2 = 1'b0;
    end
    @(posedge clk);
    if (r) begin
      m_clear_left = NP; m_drawing = 0; m_front = 0; m_frames = 0;
    end else if (m_clear_left > 0) begin
      m_clear_left--;
      if (m_clear_left == 0) m_drawing = 1;
    end else if (m_drawing) begin
      if (dn) m_drawing = 0;
    end else if (sw) begin
      m_front = ~m_front; m_frames = (m_frames + 1) % (1 << FW); m_clear_left = NP;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check2(input int a2, input bit e);
    chk2 = 1'b1; a2_force = 4'(a2); exp2 = e;
  endtask

  // monitor: outputs are presented every cycle; compare on the falling edge
  always @(negedge clk) begin
    logic [EW-1:0] exp_v, act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = pack(wr_en, wr_bank, wr_addr, wr_data, draw_ready, front_bank, int'(frame_count));
      n_assert++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs t=%0t {en,bank,addr,data,rdy,front,cnt} got %h want %h",
                 $time, act_v, exp_v);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    // reset values
    step(1, 0, 0, 0, 0, 0);
    // 1: eight clear cycles into bank 1, ready on the ninth
    idle(9);
    // 2: pass-through writes; 3x3 instance checks the range boundary
    check2(9, 1'b0);  step(0, 0, 1, 5, 1, 0);
    check2(8, 1'b1);  step(0, 0, 1, 3, 0, 0);
    check2(15, 1'b0); step(0, 0, 1, 2, 1, 0);
    // 3: last pixel with done, then swap, then clear into bank 0
    step(0, 0, 1, 7, 1, 1);
    idle(2);
    step(0, 1, 0, 0, 0, 0);
    idle(10);
    // 4: swap coinciding with done is ignored; the next pulse swaps
    step(0, 1, 1, 4, 1, 1);
    idle(2);
    step(0, 1, 0, 0, 0, 0);
    // 5: pulses during clear and draw are ignored
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    idle(6);
    step(0, 1, 1, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0);
    // get front_bank=1, then 6: reset while waiting
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);
    idle(9);
    step(0, 0, 0, 0, 0, 1);
    idle(1);
    step(1, 1, 0, 0, 0, 0);
    idle(10);
    // random traffic, long enough to wrap frame_count, resets late
    for (int i = 0; i < 6000; i++) begin
      step((i > 5000) && ($urandom_range(0, 299) == 0), $urandom_range(0, 3) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, NP - 1), 1'($urandom_range(0, 1)),
           $urandom_range(0, 5) == 0);
    end
    @(negedge clk);
    #1;
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain leftover %0d want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
